// File: rtl/iurt_hub_adapter.sv
// Byte-stream adapter between the IPDBG hub channel and the IURT controller.
// Down bytes are unescaped into a FIFO; up bytes pass through a one-entry holding stage.
module iurt_hub_adapter #(
    parameter int          FIFO_DEPTH_LOG2 = 4,
    parameter logic [7:0]  ESC_SYMBOL      = 8'h55,
    parameter logic [7:0]  RESET_SYMBOL    = 8'hEE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       dn_lines_valid,
    input  logic [7:0] dn_lines_data,
    input  logic       up_lines_ready,
    output logic       up_lines_valid,
    output logic [7:0] up_lines_data,
    input  logic       data_dwn_ready,
    output logic       data_dwn_valid,
    output logic [7:0] data_dwn,
    output logic       data_up_ready,
    input  logic       data_up_valid,
    input  logic [7:0] data_up,
    output logic       chan_reset,
    output logic       overflow
);

    localparam int                         DEPTH      = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0]   FULL_COUNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE    = (FIFO_DEPTH_LOG2 + 1)'(1);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = FIFO_DEPTH_LOG2'(1);

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_ESCAPED = 1'b1;

    logic                       state_q, state_d;
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
    logic                       chan_reset_q, chan_reset_d;
    logic                       overflow_q, overflow_d;
    logic                       up_valid_q, up_valid_d;
    logic [7:0]                 up_data_q, up_data_d;
    logic [7:0]                 mem_q [DEPTH];

    logic dn_fire, flush, push_req, push_ok, pop, full, up_ready;

    always_comb begin
        dn_fire  = ce && dn_lines_valid;
        flush    = dn_fire && (state_q == ST_ESCAPED) && (dn_lines_data == RESET_SYMBOL);
        push_req = dn_fire && ((state_q == ST_ESCAPED) ? (dn_lines_data != RESET_SYMBOL)
                                                       : (dn_lines_data != ESC_SYMBOL));
        pop      = (count_q != '0) && data_dwn_ready && ce;
        full     = (count_q == FULL_COUNT);
        // A full FIFO still accepts a byte when a pop frees the slot in the same cycle.
        push_ok  = push_req && (!full || pop);
        up_ready = !up_valid_q || up_lines_ready;
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        chan_reset_d = flush;
        overflow_d   = overflow_q || (push_req && full && !pop);

        if (dn_fire) begin
            if (state_q == ST_IDLE && dn_lines_data == ESC_SYMBOL) begin
                state_d = ST_ESCAPED;
            end else begin
                state_d = ST_IDLE;
            end
        end

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // The byte popped during a flush is still delivered, then everything is discarded.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_comb begin
        up_valid_d = up_valid_q;
        up_data_d  = up_data_q;
        if (data_up_valid && up_ready && ce) begin
            up_valid_d = 1'b1;
            up_data_d  = data_up;
        end else if (up_lines_ready && ce) begin
            up_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            chan_reset_q <= 1'b0;
            overflow_q   <= 1'b0;
            up_valid_q   <= 1'b0;
            up_data_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            chan_reset_q <= chan_reset_d;
            overflow_q   <= overflow_d;
            up_valid_q   <= up_valid_d;
            up_data_q    <= up_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= dn_lines_data;
        end
    end

    assign data_dwn_valid = (count_q != '0);
    assign data_dwn       = data_dwn_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign data_up_ready  = up_ready;
    assign up_lines_valid = up_valid_q;
    assign up_lines_data  = up_data_q;
    assign chan_reset     = chan_reset_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_iurt_hub_adapter.sv
// Directed bench for iurt_hub_adapter with a 4-deep down FIFO; every check is
// an immediate assertion against a hand-computed value.
module tb_iurt_hub_adapter;

    logic       clk;
    logic       rst;
    logic       ce;
    logic       dn_lines_valid;
    logic [7:0] dn_lines_data;
    logic       up_lines_ready;
    logic       up_lines_valid;
    logic [7:0] up_lines_data;
    logic       data_dwn_ready;
    logic       data_dwn_valid;
    logic [7:0] data_dwn;
    logic       data_up_ready;
    logic       data_up_valid;
    logic [7:0] data_up;
    logic       chan_reset;
    logic       overflow;

    int checks;
    int failures;

    iurt_hub_adapter #(
        .FIFO_DEPTH_LOG2(2),
        .ESC_SYMBOL     (8'h55),
        .RESET_SYMBOL   (8'hEE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ce            (ce),
        .dn_lines_valid(dn_lines_valid),
        .dn_lines_data (dn_lines_data),
        .up_lines_ready(up_lines_ready),
        .up_lines_valid(up_lines_valid),
        .up_lines_data (up_lines_data),
        .data_dwn_ready(data_dwn_ready),
        .data_dwn_valid(data_dwn_valid),
        .data_dwn      (data_dwn),
        .data_up_ready (data_up_ready),
        .data_up_valid (data_up_valid),
        .data_up       (data_up),
        .chan_reset    (chan_reset),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are observed 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present one hub down byte for exactly one clock.
    task automatic applyStimulus(input logic [7:0] b);
        dn_lines_valid = 1'b1;
        dn_lines_data  = b;
        tick();
        dn_lines_valid = 1'b0;
        dn_lines_data  = 8'h00;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        ce             = 1'b1;
        dn_lines_valid = 1'b0;
        dn_lines_data  = 8'h00;
        up_lines_ready = 1'b0;
        data_dwn_ready = 1'b0;
        data_up_valid  = 1'b0;
        data_up        = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        checkOutput("rst_up_valid", {7'b0, up_lines_valid}, 8'h00);
        checkOutput("rst_up_data", up_lines_data, 8'h00);
        checkOutput("rst_dwn_valid", {7'b0, data_dwn_valid}, 8'h00);
        checkOutput("rst_dwn_data", data_dwn, 8'h00);
        checkOutput("rst_chan_reset", {7'b0, chan_reset}, 8'h00);
        checkOutput("rst_overflow", {7'b0, overflow}, 8'h00);
        checkOutput("rst_up_ready", {7'b0, data_up_ready}, 8'h01);

        // Plain bytes, one cycle latency, consumed as they arrive.
        data_dwn_ready = 1'b1;
        applyStimulus(8'h42);
        checkOutput("plain42_valid", {7'b0, data_dwn_valid}, 8'h01);
        checkOutput("plain42_data", data_dwn, 8'h42);
        applyStimulus(8'h43);
        checkOutput("plain43_valid", {7'b0, data_dwn_valid}, 8'h01);
        checkOutput("plain43_data", data_dwn, 8'h43);
        tick();
        checkOutput("plain_drained", {7'b0, data_dwn_valid}, 8'h00);
        checkOutput("plain_overflow", {7'b0, overflow}, 8'h00);

        // Escaped escape symbol is delivered literally.
        applyStimulus(8'h55);
        checkOutput("esc_prefix_hidden", {7'b0, data_dwn_valid}, 8'h00);
        applyStimulus(8'h55);
        checkOutput("esc55_valid", {7'b0, data_dwn_valid}, 8'h01);
        checkOutput("esc55_data", data_dwn, 8'h55);
        applyStimulus(8'h55);
        checkOutput("esc_prefix2_hidden", {7'b0, data_dwn_valid}, 8'h00);
        applyStimulus(8'h12);
        checkOutput("esc12_data", data_dwn, 8'h12);
        applyStimulus(8'h55);
        checkOutput("esc_prefix3_hidden", {7'b0, data_dwn_valid}, 8'h00);
        applyStimulus(8'hEE);
        checkOutput("cmd_chan_reset", {7'b0, chan_reset}, 8'h01);
        checkOutput("cmd_no_data", {7'b0, data_dwn_valid}, 8'h00);
        tick();
        checkOutput("cmd_pulse_end", {7'b0, chan_reset}, 8'h00);

        // Full FIFO with a simultaneous pop accepts the new byte.
        data_dwn_ready = 1'b0;
        applyStimulus(8'hA0);
        applyStimulus(8'hA1);
        applyStimulus(8'hA2);
        applyStimulus(8'hA3);
        checkOutput("full_head", data_dwn, 8'hA0);
        data_dwn_ready = 1'b1;
        applyStimulus(8'hA4);
        checkOutput("fullpop_overflow", {7'b0, overflow}, 8'h00);
        checkOutput("fullpop_A1", data_dwn, 8'hA1);
        tick();
        checkOutput("fullpop_A2", data_dwn, 8'hA2);
        tick();
        checkOutput("fullpop_A3", data_dwn, 8'hA3);
        tick();
        checkOutput("fullpop_A4", data_dwn, 8'hA4);
        tick();
        checkOutput("fullpop_drained", {7'b0, data_dwn_valid}, 8'h00);

        // Overflow: only the first four of six bytes survive.
        data_dwn_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(8'(i));
        end
        checkOutput("ovf_flag", {7'b0, overflow}, 8'h01);
        checkOutput("ovf_head", data_dwn, 8'h01);
        data_dwn_ready = 1'b1;
        tick();
        checkOutput("ovf_02", data_dwn, 8'h02);
        tick();
        checkOutput("ovf_03", data_dwn, 8'h03);
        tick();
        checkOutput("ovf_04", data_dwn, 8'h04);
        tick();
        checkOutput("ovf_drained", {7'b0, data_dwn_valid}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'h80 + 8'(i));
            checkOutput("wrap_stream", data_dwn, 8'h80 + 8'(i));
        end
        tick();
        checkOutput("wrap_drained", {7'b0, data_dwn_valid}, 8'h00);

        // Flush with bytes pending; overflow remains sticky.
        data_dwn_ready = 1'b0;
        applyStimulus(8'h31);
        applyStimulus(8'h32);
        applyStimulus(8'h33);
        checkOutput("flush_pre_head", data_dwn, 8'h31);
        applyStimulus(8'h55);
        applyStimulus(8'hEE);
        checkOutput("flush_valid", {7'b0, data_dwn_valid}, 8'h00);
        checkOutput("flush_chan_reset", {7'b0, chan_reset}, 8'h01);
        checkOutput("flush_overflow", {7'b0, overflow}, 8'h01);
        data_dwn_ready = 1'b1;
        applyStimulus(8'h77);
        checkOutput("post_flush_valid", {7'b0, data_dwn_valid}, 8'h01);
        checkOutput("post_flush_data", data_dwn, 8'h77);
        tick();
        checkOutput("post_flush_drained", {7'b0, data_dwn_valid}, 8'h00);

        // Up path: hold under backpressure, then stream.
        up_lines_ready = 1'b0;
        data_up_valid  = 1'b1;
        data_up        = 8'hA5;
        tick();
        data_up_valid  = 1'b0;
        data_up        = 8'h00;
        checkOutput("up_hold_valid", {7'b0, up_lines_valid}, 8'h01);
        checkOutput("up_hold_data", up_lines_data, 8'hA5);
        checkOutput("up_hold_ready", {7'b0, data_up_ready}, 8'h00);
        up_lines_ready = 1'b1;
        #1;
        checkOutput("up_release_ready", {7'b0, data_up_ready}, 8'h01);
        tick();
        checkOutput("up_consumed", {7'b0, up_lines_valid}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            data_up_valid = 1'b1;
            data_up       = 8'hB0 + 8'(i);
            tick();
            checkOutput("up_stream_valid", {7'b0, up_lines_valid}, 8'h01);
            checkOutput("up_stream_data", up_lines_data, 8'hB0 + 8'(i));
        end
        data_up_valid = 1'b0;
        tick();
        checkOutput("up_stream_end", {7'b0, up_lines_valid}, 8'h00);

        // Reset drops the ESCAPED state; the next EE is literal.
        applyStimulus(8'h55);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_rst_overflow", {7'b0, overflow}, 8'h00);
        applyStimulus(8'hEE);
        checkOutput("rst_literal_valid", {7'b0, data_dwn_valid}, 8'h01);
        checkOutput("rst_literal_data", data_dwn, 8'hEE);
        checkOutput("rst_literal_no_cmd", {7'b0, chan_reset}, 8'h00);
        tick();

        // A byte offered with ce low is ignored.
        ce = 1'b0;
        applyStimulus(8'h66);
        ce = 1'b1;
        checkOutput("ce_low_ignored", {7'b0, data_dwn_valid}, 8'h00);
        tick();
        checkOutput("ce_low_still_empty", {7'b0, data_dwn_valid}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
